// File: rtl/ball_pkg.sv
// Shared types and width helpers for the ball collision resolver.
package ball_pkg;
   typedef enum logic [2:0] {
      IDLE,
      CALC,
      DIV,
      APPLY,
      DONE
   } state_t;

   localparam int N_DEF    = 32;
   localparam int FRAC_DEF = 16;

   // Signed width that holds dx*dx+dy*dy (and the dot product) exactly.
   function automatic int prod_w(input int n);
      return 2 * n + 1;
   endfunction
endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider: QW quotient bits, one per clock, MSB first.
module seq_udiv #(
   parameter int DW = 81,
   parameter int VW = 65,
   parameter int QW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_start,
   input  logic [DW-1:0] i_dividend,
   input  logic [VW-1:0] i_divisor,
   output logic          o_busy,
   output logic          o_done,
   output logic [QW-1:0] o_quot
);
   localparam int CNTW = $clog2(QW + 1);

   logic [VW-1:0]   r_rem;
   logic [VW-1:0]   r_div;
   logic [QW-1:0]   r_low;
   logic [QW-1:0]   r_quot;
   logic [CNTW-1:0] r_cnt;
   logic            r_busy;

   logic [VW:0]     w_shift;
   logic [VW-1:0]   w_diff;
   logic            w_ge;

   assign w_shift = {r_rem, r_low[QW-1]};
   assign w_ge    = w_shift >= {1'b0, r_div};
   assign w_diff  = w_shift[VW-1:0] - r_div;

   // o_done flags the cycle whose closing edge writes the last quotient bit.
   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == CNTW'(1));
   assign o_quot = r_quot;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_div  <= '0;
         r_low  <= '0;
         r_quot <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= CNTW'(QW);
         r_rem  <= VW'(i_dividend >> QW);
         r_low  <= i_dividend[QW-1:0];
         r_div  <= i_divisor;
         r_quot <= '0;
      end else if (r_busy) begin
         r_rem  <= w_ge ? w_diff : w_shift[VW-1:0];
         r_low  <= r_low << 1;
         r_quot <= {r_quot[QW-2:0], w_ge};
         r_cnt  <= r_cnt - CNTW'(1);
         if (r_cnt == CNTW'(1)) r_busy <= 1'b0;
      end
   end
endmodule

// File: rtl/ball_collision_resolve.sv
// Equal-mass elastic response for one pair of colliding balls,
// fixed-point, with a bit-serial divide for the impulse scale k.
module ball_collision_resolve
   import ball_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic signed [N-1:0] x0,
   input  logic signed [N-1:0] y0,
   input  logic signed [N-1:0] x1,
   input  logic signed [N-1:0] y1,
   input  logic signed [N-1:0] vx0,
   input  logic signed [N-1:0] vy0,
   input  logic signed [N-1:0] vx1,
   input  logic signed [N-1:0] vy1,
   output logic                ready,
   output logic                done,
   output logic signed [N-1:0] nvx0,
   output logic signed [N-1:0] nvy0,
   output logic signed [N-1:0] nvx1,
   output logic signed [N-1:0] nvy1
);
   localparam int PW = prod_w(N);
   localparam int DW = PW + FRAC;
   localparam int CW = PW + N;
   localparam int XW = 2 * N + 2;
   localparam logic [N-1:0] KMAX = {1'b0, {(N-1){1'b1}}};

   state_t r_state;
   state_t w_next;

   logic signed [N-1:0] r_x0, r_y0, r_x1, r_y1;
   logic signed [N-1:0] r_vx0, r_vy0, r_vx1, r_vy1;
   logic signed [N-1:0] r_nvx0, r_nvy0, r_nvx1, r_nvy1;
   logic                r_done;
   logic                r_pass;
   logic                r_sat;

   logic signed [N-1:0]  w_dx, w_dy, w_dvx, w_dvy;
   logic signed [PW-1:0] w_dot;
   logic signed [PW-1:0] w_d2s;
   logic [PW-1:0]        w_dist2;
   logic [PW-1:0]        w_mag;
   logic [DW-1:0]        w_num;
   logic                 w_pass;
   logic                 w_sat;
   logic                 w_div_start;
   logic                 w_div_busy;
   logic                 w_div_done;
   logic [N-1:0]         w_quot;
   logic [N-1:0]         w_kmag;
   logic signed [N:0]    w_k;
   logic signed [XW-1:0] w_px, w_py;
   logic signed [N-1:0]  w_ix, w_iy;

   // Differences wrap to N bits: touching balls are close, so the
   // dot product and squared distance then fit PW bits exactly.
   assign w_dx  = r_x0 - r_x1;
   assign w_dy  = r_y0 - r_y1;
   assign w_dvx = r_vx0 - r_vx1;
   assign w_dvy = r_vy0 - r_vy1;

   assign w_dot   = PW'(w_dvx) * PW'(w_dx) + PW'(w_dvy) * PW'(w_dy);
   assign w_d2s   = PW'(w_dx) * PW'(w_dx) + PW'(w_dy) * PW'(w_dy);
   assign w_dist2 = $unsigned(w_d2s);
   assign w_mag   = w_dot[PW-1] ? $unsigned(-w_dot) : $unsigned(w_dot);
   assign w_num   = {w_mag, {FRAC{1'b0}}};
   assign w_pass  = !w_dot[PW-1] || (w_dist2 == '0);
   assign w_sat   = CW'(w_num) >= (CW'(w_dist2) << (N - 1));

   assign w_div_start = (r_state == CALC) && !w_pass;

   seq_udiv #(
      .DW(DW),
      .VW(PW),
      .QW(N)
   ) u_div (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_div_start),
      .i_dividend(w_num),
      .i_divisor (w_dist2),
      .o_busy    (w_div_busy),
      .o_done    (w_div_done),
      .o_quot    (w_quot)
   );

   // k is always negative here: only approaching pairs get this far.
   assign w_kmag = r_sat ? KMAX : w_quot;
   assign w_k    = -$signed({1'b0, w_kmag});
   assign w_px   = XW'(w_k) * XW'(w_dx);
   assign w_py   = XW'(w_k) * XW'(w_dy);
   assign w_ix   = N'(w_px >>> FRAC);
   assign w_iy   = N'(w_py >>> FRAC);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next = CALC;
         CALC:    w_next = w_pass ? APPLY : DIV;
         DIV:     if (w_div_done || !w_div_busy) w_next = APPLY;
         APPLY:   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign ready = (r_state == IDLE);
   assign done  = r_done;
   assign nvx0  = r_nvx0;
   assign nvy0  = r_nvy0;
   assign nvx1  = r_nvx1;
   assign nvy1  = r_nvy1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_sat   <= 1'b0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_vx0   <= '0;
         r_vy0   <= '0;
         r_vx1   <= '0;
         r_vy1   <= '0;
         r_nvx0  <= '0;
         r_nvy0  <= '0;
         r_nvx1  <= '0;
         r_nvy1  <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == APPLY);
         if (r_state == IDLE && start) begin
            r_x0  <= x0;
            r_y0  <= y0;
            r_x1  <= x1;
            r_y1  <= y1;
            r_vx0 <= vx0;
            r_vy0 <= vy0;
            r_vx1 <= vx1;
            r_vy1 <= vy1;
         end
         if (r_state == CALC) begin
            r_pass <= w_pass;
            r_sat  <= w_sat;
         end
         if (r_state == APPLY) begin
            if (r_pass) begin
               r_nvx0 <= r_vx0;
               r_nvy0 <= r_vy0;
               r_nvx1 <= r_vx1;
               r_nvy1 <= r_vy1;
            end else begin
               r_nvx0 <= r_vx0 - w_ix;
               r_nvy0 <= r_vy0 - w_iy;
               r_nvx1 <= r_vx1 + w_ix;
               r_nvy1 <= r_vy1 + w_iy;
            end
         end
      end
   end
endmodule

// File: tb/tb_ball_collision_resolve.sv
// Scoreboard bench for ball_collision_resolve (N=32, Q16.16).
module tb_ball_collision_resolve;
   localparam int N = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic signed [N-1:0] x0, y0, x1, y1, vx0, vy0, vx1, vy1;
   logic                ready, done;
   logic signed [N-1:0] nvx0, nvy0, nvx1, nvy1;

   typedef struct {
      logic signed [N-1:0] vx0;
      logic signed [N-1:0] vy0;
      logic signed [N-1:0] vx1;
      logic signed [N-1:0] vy1;
      longint              lat;
      longint              acc;
   } exp_t;

   exp_t   sb[$];
   int     n_chk = 0;
   int     n_pass = 0;
   longint cyc = 0;
   longint last_done = -1;
   bit     held = 1'b0;
   logic   prev_done = 1'b0;

   ball_collision_resolve #(.N(N), .FRAC(16)) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .x0   (x0),
      .y0   (y0),
      .x1   (x1),
      .y1   (y1),
      .vx0  (vx0),
      .vy0  (vy0),
      .vx1  (vx1),
      .vy1  (vy1),
      .ready(ready),
      .done (done),
      .nvx0 (nvx0),
      .nvy0 (nvy0),
      .nvx1 (nvx1),
      .nvy1 (nvy1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic signed [N-1:0] ax0, ay0, ax1, ay1,
                                  input logic signed [N-1:0] avx0, avy0, avx1, avy1);
      exp_t e;
      logic signed [N-1:0] dx, dy, dvx, dvy;
      logic signed [127:0] dot, d2, num, k, ix, iy;
      dx  = ax0 - ax1;
      dy  = ay0 - ay1;
      dvx = avx0 - avx1;
      dvy = avy0 - avy1;
      dot = 128'(dvx) * 128'(dx) + 128'(dvy) * 128'(dy);
      d2  = 128'(dx) * 128'(dx) + 128'(dy) * 128'(dy);
      e.vx0 = avx0;
      e.vy0 = avy0;
      e.vx1 = avx1;
      e.vy1 = avy1;
      e.lat = 2;
      e.acc = 0;
      if (dot < 0 && d2 != 0) begin
         num = (-dot) <<< 16;
         if (num >= (d2 <<< 31)) k = 128'sd2147483647;
         else k = num / d2;
         k  = -k;
         ix = (k * 128'(dx)) >>> 16;
         iy = (k * 128'(dy)) >>> 16;
         e.vx0 = avx0 - ix[N-1:0];
         e.vy0 = avy0 - iy[N-1:0];
         e.vx1 = avx1 + ix[N-1:0];
         e.vy1 = avy1 + iy[N-1:0];
         e.lat = N + 2;
      end
      return e;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (done) begin
         chk("done_one_cycle", prev_done, 1'b0);
         if (sb.size() == 0) begin
            chk("spurious_done", done, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("nvx0", nvx0, e.vx0);
            chk("nvy0", nvy0, e.vy0);
            chk("nvx1", nvx1, e.vx1);
            chk("nvy1", nvy1, e.vy1);
            chk("latency", cyc - e.acc, e.lat);
         end
         last_done = cyc;
      end
      prev_done = done;
      if (start && ready && !reset) begin
         if (held && last_done >= 0) chk("idle_gap", cyc + 1 - last_done, 2);
         e = model(x0, y0, x1, y1, vx0, vy0, vx1, vy1);
         e.acc = cyc + 1;
         sb.push_back(e);
      end
   end

   task automatic set_in(input logic signed [N-1:0] a, b, c, d, e, f, g, h);
      x0 = a; y0 = b; x1 = c; y1 = d;
      vx0 = e; vy0 = f; vx1 = g; vy1 = h;
   endtask

   task automatic req(input logic signed [N-1:0] a, b, c, d, e, f, g, h);
      set_in(a, b, c, d, e, f, g, h);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      set_in(32'sh5a5a5a5a, 32'sh1234, -32'sh777, 32'sh0, 32'sh4444, -32'sh1, 32'sh99, 32'sh7);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((sb.size() != 0 || !ready) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, sb.size(), 0);
   endtask

   function automatic logic signed [N-1:0] rnd(input int span);
      return N'(int'($urandom_range(0, 2 * span)) - span);
   endfunction

   initial begin
      reset = 1'b1;
      start = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_ready", ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_nvx0", nvx0, 0);
      chk("rst_nvy1", nvy1, 0);

      req(0, 0, 32'sh00020000, 0, 32'sh00010000, 0, 0, 0);
      drain("drain_headon");
      chk("ho_nvx0", nvx0, 0);
      chk("ho_nvx1", nvx1, 32'sh00010000);
      chk("ho_nvy0", nvy0, 0);

      req(0, 0, 32'sh00010000, 32'sh00010000, 32'sh00010000, 0, 0, 0);
      drain("drain_glance");
      chk("gl_nvx0", nvx0, 32'sh00008000);
      chk("gl_nvy0", nvy0, 32'shFFFF8000);
      chk("gl_nvx1", nvx1, 32'sh00008000);
      chk("gl_nvy1", nvy1, 32'sh00008000);

      req(0, 0, 32'sh00020000, 0, 32'shFFFF0000, 0, 0, 0);
      drain("drain_separate");
      chk("sep_nvx0", nvx0, 32'shFFFF0000);

      req(32'sh30000, -32'sh8000, 32'sh30000, -32'sh8000,
          32'sh12345, -32'sh2222, -32'sh40000, 32'sh777);
      drain("drain_coincident");

      req(0, 0, 1, 0, 32'sh40000000, 0, 0, 0);
      drain("drain_saturate");

      for (int i = 0; i < 16; i++) begin
         req(rnd(32'h40000), rnd(32'h40000), rnd(32'h40000), rnd(32'h40000),
             rnd(32'h30000), rnd(32'h30000), rnd(32'h30000), rnd(32'h30000));
         drain("drain_random");
      end

      req(0, 0, 32'sh00020000, 0, 32'sh00010000, 0, 0, 0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_ready", ready, 1'b1);
      chk("midrst_done", done, 1'b0);
      chk("midrst_nvx1", nvx1, 0);
      sb.delete();
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_over_start", ready, 1'b1);
      reset = 1'b0;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      req(0, 0, 32'sh00010000, 32'sh00010000, 32'sh00010000, 0, 0, 0);
      drain("drain_after_rst");

      held = 1'b1;
      last_done = -1;
      start = 1'b1;
      for (int i = 0; i < 160; i++) begin
         set_in(rnd(32'h40000), rnd(32'h40000), rnd(32'h40000), rnd(32'h40000),
                rnd(32'h30000), rnd(32'h30000), rnd(32'h30000), rnd(32'h30000));
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      drain("drain_held");
      held = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
